cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Arbitrates the icache and dcache miss/writeback requests onto a single shared RAM port.
//  Sits between the caches block and the RAM model or bus.
//  Dcache has priority, bounded by a starvation counter so instruction fetch always progresses.
//  Generates the per-cache wait signals the caches use as completion handshakes.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive dcache grants, taken while iREN is pending, before one icache grant is forced (>=1)
//  AW            32  address width
//  DW            32  data width
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   asynchronous reset, active-high
//  iREN      in   1   icache read request
//  iaddr     in   AW  icache read address
//  iwait     out  1   0 = icache access completes this cycle
//  iload     out  DW  icache read data, valid when iwait=0
//  dREN      in   1   dcache read request
//  dWEN      in   1   dcache write request
//  daddr     in   AW  dcache address
//  dstore    in   DW  dcache write data
//  dwait     out  1   0 = dcache access completes this cycle
//  dload     out  DW  dcache read data, valid when dwait=0
//  ramREN    out  1   RAM read strobe
//  ramWEN    out  1   RAM write strobe
//  ramaddr   out  AW  RAM address
//  ramstore  out  DW  RAM write data
//  ramload   in   DW  RAM read data, valid with ram_ready
//  ram_ready in   1   RAM completes the current access this cycle; may be high the same cycle as the strobe
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE, starve_cnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
//  FSM states: IDLE, IACC, DACC (registered). Outputs are combinational from state and live inputs.
//  IDLE: all RAM strobes 0; iwait=dwait=1. Arbitration at the clock edge:
//   - dREN|dWEN, and not (iREN & starve_cnt==STARVE_LIMIT) -> DACC.
//     If iREN is high, starve_cnt++ (saturating at STARVE_LIMIT); otherwise starve_cnt=0.
//   - else iREN -> IACC; starve_cnt=0.
//   - else stay in IDLE.
//  IACC: ramREN=1, ramWEN=0, ramaddr=iaddr, iwait=~ram_ready, iload=ramload; dwait=1.
//  DACC: ramWEN=dWEN, ramREN=dREN&~dWEN (dWEN wins if both are high), ramaddr=daddr, ramstore=dstore.
//   dwait=~ram_ready, dload=ramload; iwait=1.
//  ACC -> IDLE when ram_ready=1, or when the granted request drops (abandoned access).
//   On an abandoned access, RAM strobes drop the same cycle the request drops, and no wait goes low.
//  Latency: request seen in IDLE at edge N; strobes asserted in cycle N+1; with an immediate ram_ready, wait=0 in cycle N+1.
//   The arbiter is back in IDLE at N+2. Minimum 2 cycles per access; one IDLE bubble between back-to-back accesses.
//  Requesters must hold address, data and request until their wait=0; the arbiter does not latch them.
//  Simultaneous iREN and dREN/dWEN in IDLE: dcache wins unless the starve limit has been reached.
//   iload and dload always carry ramload; only the wait signals qualify them.
//  Wait is never low for the non-granted requester. ram_ready while in IDLE is ignored.
//  Reset mid-access: immediate return to IDLE with strobes low. The access is lost and the requester re-issues it.
// TESTING
//  1. Reset, only iREN=1, iaddr=0x40, ram_ready=1 immediately -> ramREN=1, ramaddr=0x40 in cycle 1.
//     iwait=0 in cycle 1, iload=ramload; back in IDLE in cycle 2.
//  2. iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> DACC first, ramWEN=1, ramstore=0xDEADBEEF.
//     IACC follows after a single IDLE cycle.
//  3. iREN held with continuous dREN, STARVE_LIMIT=4 -> 4 dcache grants, then 1 icache grant, then starve_cnt=0.
//  4. ram_ready delayed 3 cycles in DACC read -> dwait=1 for 2 strobe cycles, 0 on the 3rd.
//     ramREN held throughout; iwait=1 throughout.
//  5. dREN=dWEN=1 -> ramWEN=1, ramREN=0. dREN dropped mid-DACC before ram_ready -> IDLE next cycle, dwait never 0.
//  6. RST asserted while in IACC -> strobes drop asynchronously, iwait=dwait=1; after release, a fresh arbitration from IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between icache and dcache, dcache first with a starvation bound
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_iren,
    input  logic [AW-1:0] i_iaddr,
    output logic          o_iwait,
    output logic [DW-1:0] o_iload,
    input  logic          i_dren,
    input  logic          i_dwen,
    input  logic [AW-1:0] i_daddr,
    input  logic [DW-1:0] i_dstore,
    output logic          o_dwait,
    output logic [DW-1:0] o_dload,
    output logic          o_ramren,
    output logic          o_ramwen,
    output logic [AW-1:0] o_ramaddr,
    output logic [DW-1:0] o_ramstore,
    input  logic [DW-1:0] i_ramload,
    input  logic          i_ram_ready
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    state_t          r_state;
    logic [CW-1:0]   r_starve;
    logic            w_dreq, w_starved, w_iacc, w_dacc;
    assign w_dreq    = i_dren | i_dwen;
    assign w_starved = i_iren && (r_starve == CW'(STARVE_LIMIT));
    assign w_iacc    = r_state == IACC;
    assign w_dacc    = r_state == DACC;
    // Strobes and waits follow the live request so an abandoned access drops out the same cycle
    assign o_ramren   = w_iacc ? i_iren : (w_dacc & i_dren & ~i_dwen);
    assign o_ramwen   = w_dacc & i_dwen;
    assign o_ramaddr  = w_iacc ? i_iaddr : w_dacc ? i_daddr : '0;
    assign o_ramstore = w_dacc ? i_dstore : '0;
    assign o_iwait    = ~(w_iacc & i_iren & i_ram_ready);
    assign o_dwait    = ~(w_dacc & w_dreq & i_ram_ready);
    assign o_iload    = i_ramload;
    assign o_dload    = i_ramload;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dreq && !w_starved) begin
                        r_state  <= DACC;
                        r_starve <= i_iren ? r_starve + 1'b1 : '0;
                    end else if (i_iren) begin
                        r_state  <= IACC;
                        r_starve <= '0;
                    end
                end
                IACC: if (i_ram_ready || !i_iren) r_state <= IDLE;
                DACC: if (i_ram_ready || !w_dreq) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus randomized traffic against a grant-level reference model
module tb_cache_mem_arbiter;
    localparam int LIM = 4;
    logic        clk = 1'b0;
    logic        rst, iren, dren, dwen, ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramren, ramwen;
    logic [31:0] iload, dload, ramaddr, ramstore;
    int          n_cmp = 0;
    int          n_err = 0;

    cache_mem_arbiter #(.STARVE_LIMIT(LIM), .AW(32), .DW(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_iren(iren), .i_iaddr(iaddr), .o_iwait(iwait), .o_iload(iload),
        .i_dren(dren), .i_dwen(dwen), .i_daddr(daddr), .i_dstore(dstore),
        .o_dwait(dwait), .o_dload(dload),
        .o_ramren(ramren), .o_ramwen(ramwen), .o_ramaddr(ramaddr), .o_ramstore(ramstore),
        .i_ramload(ramload), .i_ram_ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_out();
        iren = 0; dren = 0; dwen = 0; ready = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1; iren = 0; dren = 0; dwen = 0; ready = 1;
        iaddr = 32'h1234; daddr = 32'h5678; dstore = 32'hABCD; ramload = 32'h9999;
        #3;
        n_cmp++;
        if ({ramren, ramwen, iwait, dwait} !== 4'b0011) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0011", {ramren, ramwen, iwait, dwait});
        end
        n_cmp++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            n_err++; $display("FAIL reset_bus: got %h/%h want 0/0", ramaddr, ramstore);
        end
        @(negedge clk);
        rst = 0; ready = 0;
        tick();
    endtask

    task automatic test_icache_read();
        iren = 1; iaddr = 32'h40; ready = 1; ramload = $urandom;
        @(negedge clk);
        n_cmp++;
        if ({ramren, iwait} !== 2'b01) begin
            n_err++; $display("FAIL icache_c0_idle: got %b want 01", {ramren, iwait});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, ramwen, iwait, dwait} !== 4'b1001) begin
            n_err++; $display("FAIL icache_c1_ctrl: got %b want 1001", {ramren, ramwen, iwait, dwait});
        end
        n_cmp++;
        if (ramaddr !== 32'h40 || iload !== ramload) begin
            n_err++; $display("FAIL icache_c1_data: got addr %h load %h want 40 %h", ramaddr, iload, ramload);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, iwait} !== 2'b01) begin
            n_err++; $display("FAIL icache_c2_idle: got %b want 01", {ramren, iwait});
        end
        idle_out();
    endtask

    task automatic test_priority();
        iren = 1; iaddr = 32'h200; dwen = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ready = 1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, ramwen, iwait, dwait} !== 4'b0110) begin
            n_err++; $display("FAIL prio_dacc_ctrl: got %b want 0110", {ramren, ramwen, iwait, dwait});
        end
        n_cmp++;
        if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL prio_dacc_bus: got %h/%h want 100/deadbeef", ramaddr, ramstore);
        end
        tick();
        dwen = 0;
        @(negedge clk);
        n_cmp++;
        if ({ramren, ramwen, iwait, dwait} !== 4'b0011) begin
            n_err++; $display("FAIL prio_bubble: got %b want 0011", {ramren, ramwen, iwait, dwait});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, iwait, ramaddr} !== {2'b10, 32'h200}) begin
            n_err++; $display("FAIL prio_iacc: got %b %h want 10 200", {ramren, iwait}, ramaddr);
        end
        idle_out();
    endtask

    task automatic test_starvation();
        logic exp_i, exp_d;
        iren = 1; dren = 1; iaddr = 32'hA0; daddr = 32'hB0; ready = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_i = (c % 2 == 1) && ((c / 2) % (LIM + 1) == LIM);
            exp_d = (c % 2 == 1) && !exp_i;
            n_cmp++;
            if ({iwait, dwait, ramaddr} !== {!exp_i, !exp_d, exp_i ? 32'hA0 : exp_d ? 32'hB0 : 32'h0}) begin
                n_err++; $display("FAIL starve_c%0d: got %b%b %h want %b%b", c, iwait, dwait, ramaddr, !exp_i, !exp_d);
            end
            tick();
        end
        idle_out();
    endtask

    task automatic test_delayed_ready();
        iren = 1; dren = 1; daddr = 32'hC0; ready = 0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            ready = (k == 3);
            @(negedge clk);
            n_cmp++;
            if ({ramren, iwait, dwait} !== {2'b11, k < 3}) begin
                n_err++; $display("FAIL delay_k%0d: got %b want %b", k, {ramren, iwait, dwait}, {2'b11, k < 3});
            end
            tick();
        end
        idle_out();
    endtask

    task automatic test_abandon_and_both();
        iren = 0; dren = 1; dwen = 1; daddr = 32'hD0; dstore = $urandom; ready = 1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, ramwen, dwait} !== 3'b010 || ramstore !== dstore) begin
            n_err++; $display("FAIL both_wen: got %b %h want 010 %h", {ramren, ramwen, dwait}, ramstore, dstore);
        end
        idle_out();
        dren = 1; ready = 0;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, dwait} !== 2'b11) begin
            n_err++; $display("FAIL abandon_pre: got %b want 11", {ramren, dwait});
        end
        tick();
        dren = 0; ready = 1;
        @(negedge clk);
        n_cmp++;
        if ({ramren, ramwen, dwait} !== 3'b001) begin
            n_err++; $display("FAIL abandon_drop: got %b want 001", {ramren, ramwen, dwait});
        end
        tick();
        dren = 1;
        @(negedge clk);
        n_cmp++;
        if ({ramren, dwait} !== 2'b01) begin
            n_err++; $display("FAIL abandon_idle: got %b want 01", {ramren, dwait});
        end
        idle_out();
    endtask

    task automatic test_async_reset();
        iren = 1; iaddr = 32'hE0; ready = 0;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, iwait} !== 2'b11) begin
            n_err++; $display("FAIL areset_pre: got %b want 11", {ramren, iwait});
        end
        tick();
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({ramren, iwait, dwait} !== 3'b011 || ramaddr !== 32'h0) begin
            n_err++; $display("FAIL areset_mid: got %b %h want 011 0", {ramren, iwait, dwait}, ramaddr);
        end
        @(negedge clk);
        rst = 0; ready = 1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({ramren, iwait, ramaddr} !== {2'b10, 32'hE0}) begin
            n_err++; $display("FAIL areset_rearb: got %b %h want 10 e0", {ramren, iwait}, ramaddr);
        end
        idle_out();
    endtask

    task automatic test_random();
        int m_grant, m_run;
        logic [131:0] got, want;
        logic dreq;
        rst = 1; tick(); rst = 0;
        m_grant = 0;
        m_run = 0;
        for (int n = 0; n < 400; n++) begin
            iren = ($urandom_range(0, 3) != 0); dren = $urandom_range(0, 1); dwen = ($urandom_range(0, 3) == 0);
            ready = $urandom_range(0, 1);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            dreq = dren | dwen;
            @(negedge clk);
            want = {(m_grant == 1 && iren) || (m_grant == 2 && dren && !dwen), m_grant == 2 && dwen,
                    !(m_grant == 1 && iren && ready), !(m_grant == 2 && dreq && ready),
                    m_grant == 1 ? iaddr : m_grant == 2 ? daddr : 32'h0, m_grant == 2 ? dstore : 32'h0,
                    ramload, ramload};
            got = {ramren, ramwen, iwait, dwait, ramaddr, ramstore, iload, dload};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", n, got, want);
            end
            // m_run counts dcache grants taken in a row while the icache kept asking
            if (m_grant == 0) begin
                if (dreq && !(iren && m_run >= LIM)) begin
                    m_grant = 2;
                    m_run = iren ? m_run + 1 : 0;
                end else if (iren) begin
                    m_grant = 1;
                    m_run = 0;
                end
            end else if (ready || (m_grant == 1 ? !iren : !dreq)) begin
                m_grant = 0;
            end
            tick();
        end
        idle_out();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_priority();
        test_starvation();
        test_delayed_ready();
        test_abandon_and_both();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
